// File: rtl/sap1_ctrl_if.sv
// Control-bus interface between the SAP-1 controller and its datapath.
//   run, opcode      : datapath/host -> controller (start request, IR opcode)
//   cp..lo           : one-cycle control word, controller -> datapath
//   hlt, t_state     : machine-halted flag and one-hot phase
//   instr_done/count : retire pulse and retired-instruction counter
interface sap1_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             run;
  logic [3:0]       opcode;
  logic             cp;
  logic             ep;
  logic             lm;
  logic             ce;
  logic             li;
  logic             ei;
  logic             la;
  logic             ea;
  logic             su;
  logic             eu;
  logic             lb;
  logic             lo;
  logic             hlt;
  logic [5:0]       t_state;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, opcode,
    output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo,
    output hlt, t_state, instr_done, instr_count
  );

  modport slave (
    output run, opcode,
    input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo,
    input  hlt, t_state, instr_done, instr_count
  );
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: six-phase fetch/execute ring with opcode decode,
// retired-instruction counter and HLT hold.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sap1_ctrl_if.master (run/opcode in, control word and status out)
// The control word is a combinational decode of the registered state, with
// the opcode qualifying T4..T6; instr_count is registered.
module sap1_controller #(
  parameter logic [3:0]  OP_LDA = 4'h0,
  parameter logic [3:0]  OP_ADD = 4'h1,
  parameter logic [3:0]  OP_SUB = 4'h2,
  parameter logic [3:0]  OP_OUT = 4'hE,
  parameter logic [3:0]  OP_HLT = 4'hF,
  parameter int unsigned CNT_W  = 8
) (
  input logic         clk,
  input logic         rst,
  sap1_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;

  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt, done;
  logic [5:0] t_state;

  // State register and retired-instruction counter (wraps silently)
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_T6) count <= count + CNT_W'(1);
    end
  end

  // Next-state and control-word decode
  always_comb begin
    state_nxt = state;
    cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0; li = 1'b0; ei = 1'b0;
    la = 1'b0; ea = 1'b0; su = 1'b0; eu = 1'b0; lb = 1'b0; lo = 1'b0;
    hlt     = 1'b0;
    done    = 1'b0;
    t_state = 6'b000000;
    case (state)
      S_IDLE: if (bus.run) state_nxt = S_T1;
      S_T1: begin
        t_state = 6'b000001; state_nxt = S_T2;
        ep = 1'b1; lm = 1'b1;
      end
      S_T2: begin
        t_state = 6'b000010; state_nxt = S_T3;
        cp = 1'b1;
      end
      S_T3: begin
        t_state = 6'b000100; state_nxt = S_T4;
        ce = 1'b1; li = 1'b1;
      end
      S_T4: begin
        t_state = 6'b001000; state_nxt = S_T5;
        if (bus.opcode == OP_HLT) begin
          state_nxt = S_HALT;
        end else if (bus.opcode == OP_LDA || bus.opcode == OP_ADD ||
                     bus.opcode == OP_SUB) begin
          ei = 1'b1; lm = 1'b1;
        end else if (bus.opcode == OP_OUT) begin
          ea = 1'b1; lo = 1'b1;
        end
      end
      S_T5: begin
        t_state = 6'b010000; state_nxt = S_T6;
        if (bus.opcode == OP_LDA) begin
          ce = 1'b1; la = 1'b1;
        end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          ce = 1'b1; lb = 1'b1;
        end
      end
      S_T6: begin
        t_state = 6'b100000; state_nxt = S_T1;
        done = 1'b1;
        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          eu = 1'b1; la = 1'b1;
          su = (bus.opcode == OP_SUB);
        end
      end
      S_HALT: hlt = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.cp = cp;
  assign bus.ep = ep;
  assign bus.lm = lm;
  assign bus.ce = ce;
  assign bus.li = li;
  assign bus.ei = ei;
  assign bus.la = la;
  assign bus.ea = ea;
  assign bus.su = su;
  assign bus.eu = eu;
  assign bus.lb = lb;
  assign bus.lo = lo;
  assign bus.hlt         = hlt;
  assign bus.t_state     = t_state;
  assign bus.instr_done  = done;
  assign bus.instr_count = count;

endmodule

// File: doc/sap1_controller.md
Name: sap1_controller

Overview:
- Controller-sequencer for the 8-bit SAP-style CPU.
- Runs the six-phase fetch/execute ring (T1..T6) and decodes the instruction-register opcode.
- Drives the one-cycle control word to the program counter (cp, ep), MAR, RAM, IR, accumulator, ALU, B and output registers.
- Also keeps a retired-instruction count and holds the machine on HLT.

Parameters:
- OP_LDA, 4'h0, opcode of load-accumulator
- OP_ADD, 4'h1, opcode of add
- OP_SUB, 4'h2, opcode of subtract
- OP_OUT, 4'hE, opcode of output
- OP_HLT, 4'hF, opcode of halt
- CNT_W, 8, width of retired-instruction counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  start request; sampled only in IDLE
- opcode  in  4  IR upper nibble; must be stable T4..T6
- cp  out  1  PC increment
- ep  out  1  PC drives bus
- lm  out  1  MAR load
- ce  out  1  RAM drives bus
- li  out  1  IR load
- ei  out  1  IR address nibble drives bus
- la  out  1  accumulator load
- ea  out  1  accumulator drives bus
- su  out  1  ALU subtract select
- eu  out  1  ALU drives bus
- lb  out  1  B register load
- lo  out  1  output register load
- hlt  out  1  machine halted
- t_state  out  6  one-hot phase, bit0=T1 .. bit5=T6; 0 in IDLE/HALT
- instr_done  out  1  one-cycle pulse in T6 of a completed instruction
- instr_count  out  CNT_W  retired instructions

Behaviour:
- States: IDLE, T1..T6, HALT. State is registered. Control outputs are a combinational decode of the current state and opcode (Moore on state, with opcode qualifying T4..T6).
- Reset (rst=1 at a clock edge, from any state, including mid-instruction): next state IDLE, instr_count=0. During IDLE all controls, hlt, instr_done and t_state are 0.
- IDLE -> T1 when run=1; otherwise stay in IDLE.
- T1->T2->T3->T4->T5->T6->T1 unconditionally. Exception: HLT in T4.
- Fetch, identical for every opcode:
  - T1: ep, lm
  - T2: cp
  - T3: ce, li
- Execute:
  - LDA: T4 ei,lm; T5 ce,la; T6 none
  - ADD: T4 ei,lm; T5 ce,lb; T6 eu,la (su=0)
  - SUB: as ADD, except T6 eu,la,su
  - OUT: T4 ea,lo; T5/T6 none
  - Any other opcode except HLT: NOP, with no controls in T4..T6; still retires
- HLT:
  - In T4 with opcode==OP_HLT: no bus controls, and the next state is HALT.
  - HALT: hlt=1 and all other controls 0. It is left only by rst; run is ignored.
  - HLT does not pulse instr_done and does not increment instr_count.
- In T6: instr_done=1, and instr_count increments at the end of T6. The counter wraps 2^CNT_W-1 -> 0 with no flag.
- At most one bus driver (ep, ce, ei, ea, eu) is active per cycle. The bench asserts this as an invariant.
- Latency: first instruction retires 6 cycles after leaving IDLE. Throughput is 1 instruction per 6 cycles.
- run held high after start has no effect. run asserted during HALT does not restart the machine.

Test Plan:
- Reset then run=1 for one cycle, opcode=4'h0 from T4 -> t_state sequence 000001,000010,…,100000,000001. Controls: T1 ep,lm; T2 cp; T3 ce,li; T4 ei,lm; T5 ce,la. instr_done in T6; instr_count=1 after T6.
- opcode=4'h2 (SUB) -> T5 ce,lb; T6 eu,la,su all 1. For opcode=4'h1, T6 has su=0.
- OUT then HLT program (opcode 4'hE, then 4'hF) -> lo pulses in T4 of the first instruction. Entering HALT after the second T4 gives hlt=1 and t_state=0 held ≥20 cycles with run=1. instr_count stays 1.
- rst asserted during T5 of an ADD -> next cycle IDLE, all outputs 0, instr_count=0. No la is seen at the T6 position.
- 256 NOPs (opcode 4'h7) -> no controls in T4..T6 and instr_done every 6 cycles. instr_count goes 255 -> 0 on the 256th.
- Random opcodes over 1000 instructions -> at most one of ep/ce/ei/ea/eu high every cycle, and t_state always one-hot or zero.
